// File: rtl/mod_n_sched_pkg.sv
// rtl/mod_n_sched_pkg.sv - shared state encodings and default widths for mod_n_sched
//
// Purpose : common definitions for the modulo-N run scheduler.
// Contents: state_t  - scheduler FSM states (IDLE, RUN, DONE)
//           DEF_WIDTH - default counter/modulus width
//           DEF_RPT_W - default repeat-count width
package mod_n_sched_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam int DEF_WIDTH = 9;
   localparam int DEF_RPT_W = 8;

endpackage

// File: rtl/mod_n_rt.sv
// rtl/mod_n_rt.sv - modulo counter with run-time modulus, enable, clear and wrap strobe
//
// Purpose : counts 0..modulus-1 on enabled edges and flags each wrap one cycle later.
// Ports   : clk     in  system clock
//           rst     in  asynchronous active-low reset
//           clr     in  synchronous clear (val and wrap to 0), overrides ce
//           ce      in  count enable
//           modulus in  count period N (caller keeps it stable while counting)
//           val     out current count
//           at_top  out val == N-1, i.e. the next enabled edge wraps
//           wrap    out registered pulse, high in the cycle after a wrap edge
module mod_n_rt
   import mod_n_sched_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             ce,
   input  logic [WIDTH-1:0] modulus,
   output logic [WIDTH-1:0] val,
   output logic             at_top,
   output logic             wrap
);

   localparam logic [WIDTH-1:0] ONE = 1;

   logic [WIDTH-1:0] top_val;

   // Compared at WIDTH bits; N=1 makes top_val 0 so every enabled edge wraps.
   assign top_val = modulus - ONE;
   assign at_top  = (val == top_val);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         val  <= '0;
         wrap <= 1'b0;
      end else if (clr) begin
         val  <= '0;
         wrap <= 1'b0;
      end else if (ce) begin
         wrap <= at_top;
         val  <= at_top ? '0 : val + ONE;
      end else begin
         wrap <= 1'b0;
      end
   end

endmodule

// File: rtl/mod_n_sched.sv
// rtl/mod_n_sched.sv - run-time scheduler sequencing a modulo-N counter through repeated periods
//
// Purpose : accepts start with modulus/repeat count, runs the counter for that many
//           periods (or forever when repeats=0) gated by ce, with busy/done/wrap/err.
// Ports   : clk        in  system clock
//           rst        in  asynchronous active-low reset
//           start      in  begin a run (IDLE only)
//           stop       in  abort (RUN only); beats start when both are high in IDLE
//           ce         in  count enable
//           modulus    in  period N, sampled on accepted start
//           repeats    in  number of periods, 0 = free-run
//           val        out current count 0..N-1
//           wrap       out pulse in the cycle after val went N-1 -> 0
//           busy       out high in RUN
//           done       out one-cycle completion pulse
//           wraps_left out remaining periods (0 in free-run)
//           err        out pulse when start is rejected for modulus=0
module mod_n_sched
   import mod_n_sched_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int RPT_W = DEF_RPT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             stop,
   input  logic             ce,
   input  logic [WIDTH-1:0] modulus,
   input  logic [RPT_W-1:0] repeats,
   output logic [WIDTH-1:0] val,
   output logic             wrap,
   output logic             busy,
   output logic             done,
   output logic [RPT_W-1:0] wraps_left,
   output logic             err
);

   localparam logic [RPT_W-1:0] RPT_ONE = 1;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] mod_q;
   logic [RPT_W-1:0] rpt_q;
   logic [RPT_W-1:0] left_q;
   logic             err_q;

   logic             accept;
   logic             abort;
   logic             err_d;
   logic             cnt_ce;
   logic             cnt_clr;
   logic             at_top;
   logic             period_end;

   mod_n_rt #(.WIDTH(WIDTH)) u_cnt (
      .clk     (clk),
      .rst     (rst),
      .clr     (cnt_clr),
      .ce      (cnt_ce),
      .modulus (mod_q),
      .val     (val),
      .at_top  (at_top),
      .wrap    (wrap)
   );

   // A wrap edge that consumes a counted period (only when a repeat count was given).
   assign period_end = cnt_ce && at_top && (rpt_q != '0);

   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      abort   = 1'b0;
      err_d   = 1'b0;
      cnt_ce  = 1'b0;
      cnt_clr = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            // stop suppresses both acceptance and the modulus=0 error
            if (start && !stop) begin
               if (modulus != '0) begin
                  accept  = 1'b1;
                  cnt_clr = 1'b1;
                  state_d = ST_RUN;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         ST_RUN: begin
            if (stop) begin
               abort   = 1'b1;
               cnt_clr = 1'b1;
               state_d = ST_IDLE;
            end else if (ce) begin
               cnt_ce = 1'b1;
               if (at_top && (rpt_q != '0) && (left_q == RPT_ONE)) begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         mod_q   <= '0;
         rpt_q   <= '0;
         left_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         err_q   <= err_d;
         if (accept) begin
            mod_q  <= modulus;
            rpt_q  <= repeats;
            left_q <= repeats;
         end else if (abort) begin
            left_q <= '0;
         end else if (period_end) begin
            left_q <= left_q - RPT_ONE;
         end
      end
   end

   assign busy       = (state_q == ST_RUN);
   assign done       = (state_q == ST_DONE);
   assign wraps_left = left_q;
   assign err        = err_q;

endmodule

// File: tb/tb_mod_n_sched.sv
// tb/tb_mod_n_sched.sv - randomized self-checking bench for mod_n_sched against a behavioural model
module tb_mod_n_sched;

   localparam int WIDTH = 9;
   localparam int RPT_W = 8;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             start = 1'b0;
   logic             stop = 1'b0;
   logic             ce = 1'b0;
   logic [WIDTH-1:0] modulus = '0;
   logic [RPT_W-1:0] repeats = '0;
   logic [WIDTH-1:0] val;
   logic             wrap;
   logic             busy;
   logic             done;
   logic [RPT_W-1:0] wraps_left;
   logic             err;

   int n_checks = 0;
   int n_fail   = 0;

   // behavioural model: a run is "active" with a captured period and periods remaining
   bit m_active, m_done, m_wrap, m_err;
   int m_n, m_rpt, m_val, m_left;

   mod_n_sched #(.WIDTH(WIDTH), .RPT_W(RPT_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .stop       (stop),
      .ce         (ce),
      .modulus    (modulus),
      .repeats    (repeats),
      .val        (val),
      .wrap       (wrap),
      .busy       (busy),
      .done       (done),
      .wraps_left (wraps_left),
      .err        (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_active = 0; m_done = 0; m_wrap = 0; m_err = 0;
      m_n = 0; m_rpt = 0; m_val = 0; m_left = 0;
   endtask

   // One rising edge of behaviour, computed from the current inputs.
   task automatic model_step();
      bit nw, ne, nd;
      nw = 0; ne = 0; nd = 0;
      if (m_done) begin
         // completion cycle: always returns to idle, start ignored
      end else if (!m_active) begin
         if (start && !stop) begin
            if (int'(modulus) != 0) begin
               m_n = int'(modulus); m_rpt = int'(repeats);
               m_val = 0; m_left = m_rpt; m_active = 1;
            end else begin
               ne = 1;
            end
         end
      end else if (stop) begin
         m_active = 0; m_val = 0; m_left = 0;
      end else if (ce) begin
         if (m_val == m_n - 1) begin
            m_val = 0; nw = 1;
            if (m_rpt != 0) begin
               m_left = m_left - 1;
               if (m_left == 0) begin
                  m_active = 0; nd = 1;
               end
            end
         end else begin
            m_val = m_val + 1;
         end
      end
      m_wrap = nw; m_err = ne; m_done = nd;
   endtask

   task automatic compare_all(input string pfx);
      check({pfx, "_val"},  int'(val),        m_val);
      check({pfx, "_wrap"}, int'(wrap),       int'(m_wrap));
      check({pfx, "_busy"}, int'(busy),       int'(m_active));
      check({pfx, "_done"}, int'(done),       int'(m_done));
      check({pfx, "_left"}, int'(wraps_left), m_left);
      check({pfx, "_err"},  int'(err),        int'(m_err));
   endtask

   task automatic tick(input string pfx);
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare_all(pfx);
   endtask

   task automatic set_in(input bit s, input bit sp, input bit c, input int m, input int r);
      start = s; stop = sp; ce = c;
      modulus = WIDTH'(m); repeats = RPT_W'(r);
   endtask

   // Asynchronous reset between edges; outputs must clear without a clock edge.
   task automatic mid_reset(input string pfx);
      #2 rst = 1'b0;
      #1 model_reset();
      compare_all(pfx);
      @(negedge clk);
      compare_all(pfx);
      rst = 1'b1;
   endtask

   int exp_val1 [6] = '{1, 2, 0, 1, 2, 0};
   int exp_wrap1[6] = '{0, 0, 1, 0, 0, 1};

   initial begin
      model_reset();
      rst = 1'b0;
      repeat (2) @(negedge clk);
      compare_all("reset");
      rst = 1'b1;

      // N=3, two periods, continuous ce
      set_in(1, 0, 1, 3, 2);
      tick("s1_start");
      check("s1_busy0", int'(busy), 1);
      start = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick("s1");
         check("s1_val_const", int'(val), exp_val1[i]);
         check("s1_wrap_const", int'(wrap), exp_wrap1[i]);
      end
      check("s1_done_const", int'(done), 1);
      tick("s1_end");
      check("s1_idle_const", int'(busy), 0);

      // N=4 free-run with alternating ce, then stop
      set_in(1, 0, 1, 4, 0);
      tick("s2_start");
      start = 1'b0;
      for (int i = 0; i < 21; i++) begin
         ce = (i % 2 == 0);
         tick("s2");
      end
      stop = 1'b1;
      tick("s2_stop");
      stop = 1'b0;
      tick("s2_after");

      // N=0 rejected
      set_in(1, 0, 1, 0, 3);
      tick("s3_err");
      check("s3_err_const", int'(err), 1);
      start = 1'b0;
      tick("s3_clear");

      // start with stop in IDLE: stop wins, no error
      set_in(1, 1, 1, 0, 1);
      tick("s3b");

      // N=2: stop on what would be the wrap edge
      set_in(1, 0, 1, 2, 3);
      tick("s4_start");
      start = 1'b0;
      tick("s4_cnt");
      stop = 1'b1;
      tick("s4_stop");
      check("s4_nowrap_const", int'(wrap), 0);
      stop = 1'b0;

      // N=5 one period, start re-asserted with N=2 during the run
      set_in(1, 0, 1, 5, 1);
      tick("s5_start");
      modulus = WIDTH'(2);
      for (int i = 0; i < 6; i++) tick("s5");
      start = 1'b0;

      // largest modulus, one period
      set_in(1, 0, 1, (1 << WIDTH) - 1, 1);
      tick("s7_start");
      start = 1'b0;
      for (int i = 0; i < (1 << WIDTH) + 1; i++) tick("s7");

      // reset mid-run, then N=1 with two periods
      set_in(1, 0, 1, 5, 0);
      tick("s6_start");
      start = 1'b0;
      repeat (3) tick("s6_run");
      mid_reset("s6_rst");
      tick("s6_post");
      set_in(1, 0, 1, 1, 2);
      tick("s6_n1start");
      start = 1'b0;
      repeat (3) tick("s6_n1");

      // random traffic
      for (int i = 0; i < 4000; i++) begin
         start   = ($urandom_range(0, 3) == 0);
         stop    = ($urandom_range(0, 24) == 0);
         ce      = ($urandom_range(0, 3) != 0);
         modulus = ($urandom_range(0, 15) == 0) ? WIDTH'($urandom) : WIDTH'($urandom_range(0, 6));
         repeats = RPT_W'($urandom_range(0, 3));
         if ($urandom_range(0, 499) == 0) mid_reset("rnd_rst");
         else tick("rnd");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
